// File: rtl/sd_spi_byte_master.sv
// Byte-wide SPI mode-0 master for the SD card pins; chip select is a software-held level.
// Optional macro SD_SPI_FAST_EN: fast_sel picks FAST_DIV or SLOW_DIV per byte; otherwise every byte uses SLOW_DIV.
module sd_spi_byte_master #(
    parameter int SLOW_DIV = 64,
    parameter int FAST_DIV = 2
) (
    input  logic       clk_chipset,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic       fast_sel,
    input  logic       cs_set,
    input  logic       cs_val,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       SD_n_CS,
    output logic       SD_CK,
    output logic       SD_DI,
    input  logic       SD_DO
);

    // Handshake: start and cs_set are honoured only in a cycle where busy=0
    // (IDLE, or the FIN cycle in which done is high); otherwise they are dropped.
    typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} state_t;

    localparam logic [7:0] SLOW_DIV8 = SLOW_DIV[7:0];

    state_t     state;
    logic [7:0] hc;
    logic [7:0] div_q;
    logic [6:0] tx_q;
    logic [7:0] rx_q;
    logic [2:0] bit_cnt;
    logic [7:0] sel_div;

`ifdef SD_SPI_FAST_EN
    localparam logic [7:0] FAST_DIV8 = FAST_DIV[7:0];
    assign sel_div = fast_sel ? FAST_DIV8 : SLOW_DIV8;
`else
    logic unused_cfg;
    assign sel_div    = SLOW_DIV8;
    assign unused_cfg = fast_sel ^ (FAST_DIV > 0);
`endif

    always_ff @(posedge clk_chipset or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            hc      <= 8'd0;
            div_q   <= 8'd0;
            tx_q    <= 7'd0;
            rx_q    <= 8'd0;
            bit_cnt <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_data <= 8'hFF;
            SD_n_CS <= 1'b1;
            SD_CK   <= 1'b0;
            SD_DI   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                // FIN is the done cycle; it accepts a new byte exactly like IDLE.
                IDLE, FIN: begin
                    if (cs_set) SD_n_CS <= ~cs_val;
                    if (start) begin
                        tx_q    <= wr_data[6:0];
                        div_q   <= sel_div;
                        hc      <= sel_div - 8'd1;
                        SD_DI   <= wr_data[7];
                        busy    <= 1'b1;
                        bit_cnt <= 3'd0;
                        state   <= LOW;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOW: begin
                    if (hc == 8'd0) begin
                        SD_CK <= 1'b1;
                        rx_q  <= {rx_q[6:0], SD_DO};
                        hc    <= div_q - 8'd1;
                        state <= HIGH;
                    end else begin
                        hc <= hc - 8'd1;
                    end
                end
                HIGH: begin
                    if (hc == 8'd0) begin
                        SD_CK <= 1'b0;
                        hc    <= div_q - 8'd1;
                        if (bit_cnt == 3'd7) begin
                            // Result, done and busy are registered here so they
                            // appear together in the FIN cycle.
                            bit_cnt <= 3'd0;
                            rd_data <= rx_q;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            SD_DI   <= 1'b1;
                            state   <= FIN;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            SD_DI   <= tx_q[6];
                            tx_q    <= {tx_q[5:0], 1'b0};
                            state   <= LOW;
                        end
                    end else begin
                        hc <= hc - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_byte_master.sv
// Bench for sd_spi_byte_master: SD card reply model, scoreboard of expected bytes/bits/timing.
module tb_sd_spi_byte_master;
    localparam int SDIV = 4;
    localparam int FDIV = 1;

    logic       clk_chipset = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       start = 1'b0;
    logic       fast_sel = 1'b0;
    logic       cs_set = 1'b0;
    logic       cs_val = 1'b0;
    logic       SD_DO;
    logic       busy, done;
    logic [7:0] rd_data;
    logic       SD_n_CS, SD_CK, SD_DI;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    int         exp_first_q[$];
    int         exp_div_q[$];
    logic       exp_bit_q[$];
    logic [7:0] card_q[$];
    logic       exp_ncs = 1'b1;

    sd_spi_byte_master #(.SLOW_DIV(SDIV), .FAST_DIV(FDIV)) dut (
        .clk_chipset(clk_chipset),
        .reset(reset),
        .wr_data(wr_data),
        .start(start),
        .fast_sel(fast_sel),
        .cs_set(cs_set),
        .cs_val(cs_val),
        .busy(busy),
        .done(done),
        .rd_data(rd_data),
        .SD_n_CS(SD_n_CS),
        .SD_CK(SD_CK),
        .SD_DI(SD_DI),
        .SD_DO(SD_DO)
    );

    // clock / reset
    always #5 clk_chipset = ~clk_chipset;
    always @(posedge clk_chipset) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_chipset);
        #1;
    endtask

    function automatic int eff_div(input logic fast);
`ifdef SD_SPI_FAST_EN
        return fast ? FDIV : SDIV;
`else
        if (fast) return SDIV;
        return SDIV;
`endif
    endfunction

    // driver: called at posedge+1, current cycle becomes cycle 0
    task automatic do_start(input logic [7:0] tx, input logic [7:0] reply, input logic fast,
                            input logic with_cs, input logic cs_v);
        int d;
        d = eff_div(fast);
        exp_q.push_back(reply);
        exp_cyc_q.push_back(cyc + 16 * d + 1);
        exp_first_q.push_back(cyc + d + 1);
        exp_div_q.push_back(d);
        for (int i = 7; i >= 0; i--) exp_bit_q.push_back(tx[i]);
        card_q.push_back(reply);
        wr_data  = tx;
        start    = 1'b1;
        fast_sel = fast;
        cs_set   = with_cs;
        cs_val   = cs_v;
        tick();
        start  = 1'b0;
        cs_set = 1'b0;
        if (with_cs) exp_ncs = ~cs_v;
    endtask

    task automatic set_cs(input logic v);
        cs_set = 1'b1;
        cs_val = v;
        tick();
        cs_set  = 1'b0;
        exp_ncs = ~v;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            tick();
            t++;
        end
        check_eq("done_timeout", exp_q.size() == 0, 1);
    endtask

    // SD card model: shifts reply out MSB first, changing SD_DO after each SD_CK fall
    int         c_cnt = 0;
    logic       c_have = 1'b0;
    logic [7:0] c_sh = 8'hFF;
    logic       c_prev = 1'b0;
    initial begin
        SD_DO = 1'b1;
        forever begin
            @(negedge clk_chipset);
            if (reset) begin
                card_q.delete();
                c_cnt  = 0;
                c_have = 1'b0;
                c_sh   = 8'hFF;
                c_prev = 1'b0;
            end else begin
                if (c_prev && !SD_CK) begin
                    c_sh = {c_sh[6:0], 1'b1};
                    c_cnt++;
                    if (c_cnt == 8) begin
                        c_cnt  = 0;
                        c_have = 1'b0;
                    end
                end
                if (!c_have && card_q.size() != 0) begin
                    c_sh   = card_q.pop_front();
                    c_have = 1'b1;
                end
                c_prev = SD_CK;
            end
            SD_DO = c_sh[7];
        end
    end

    // scoreboard monitor
    int   rise_cnt = 0;
    int   hi_len = 0;
    int   lo_len = 0;
    logic ck_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk_chipset);
            if (reset) begin
                exp_q.delete();
                exp_cyc_q.delete();
                exp_first_q.delete();
                exp_div_q.delete();
                exp_bit_q.delete();
                rise_cnt = 0;
                hi_len   = 0;
                lo_len   = 0;
                ck_prev  = 1'b0;
            end else begin
                if (SD_CK && !ck_prev) begin
                    if (rise_cnt == 0) begin
                        check_eq("first_rise_avail", exp_first_q.size() != 0, 1);
                        if (exp_first_q.size() != 0)
                            check_eq("first_rise_cycle", cyc, exp_first_q.pop_front());
                    end else if (exp_div_q.size() != 0) begin
                        check_eq("low_half_len", lo_len, exp_div_q[0]);
                    end
                    check_eq("di_avail", exp_bit_q.size() != 0, 1);
                    if (exp_bit_q.size() != 0) check_eq("sd_di_bit", SD_DI, exp_bit_q.pop_front());
                    check_eq("ncs_mid_byte", SD_n_CS, exp_ncs);
                    check_eq("busy_mid_byte", busy, 1);
                    rise_cnt++;
                    hi_len = 0;
                end
                if (!SD_CK && ck_prev) begin
                    if (exp_div_q.size() != 0) check_eq("high_half_len", hi_len, exp_div_q[0]);
                    lo_len = 0;
                end
                if (SD_CK) hi_len++;
                else lo_len++;
                if (done) begin
                    check_eq("done_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        check_eq("rd_data", rd_data, exp_q.pop_front());
                        check_eq("done_cycle", cyc, exp_cyc_q.pop_front());
                        if (exp_div_q.size() != 0) void'(exp_div_q.pop_front());
                    end
                    check_eq("rises_per_byte", rise_cnt, 8);
                    check_eq("busy_at_done", busy, 0);
                    check_eq("di_idle_at_done", SD_DI, 1);
                    check_eq("ck_low_at_done", SD_CK, 0);
                    check_eq("ncs_at_done", SD_n_CS, exp_ncs);
                    rise_cnt = 0;
                end
                ck_prev = SD_CK;
            end
        end
    end

    // stimulus
    initial begin
        logic [7:0] tx, rp;
        reset = 1'b1;
        repeat (3) tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rd_data", rd_data, 8'hFF);
        check_eq("rst_ncs", SD_n_CS, 1);
        check_eq("rst_ck", SD_CK, 0);
        check_eq("rst_di", SD_DI, 1);
        reset = 1'b0;
        repeat (2) tick();

        // select card and send A5 in the same cycle; card answers 3C
        do_start(8'hA5, 8'h3C, 1'b0, 1'b1, 1'b1);
        wait_done();
        check_eq("t2_ncs_selected", SD_n_CS, 0);
        check_eq("t2_rd_hold", rd_data, 8'h3C);

        // start and deselect hammered while busy: must be ignored
        do_start(8'hC3, 8'h81, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 16 * SDIV; i++) begin
            start   = 1'b1;
            cs_set  = 1'b1;
            cs_val  = 1'b0;
            wr_data = 8'($urandom_range(0, 255));
            tick();
        end
        start  = 1'b0;
        cs_set = 1'b0;
        wait_done();
        repeat (2) tick();
        check_eq("t3_ncs_kept", SD_n_CS, 0);
        check_eq("t3_single_done", done, 0);
        set_cs(1'b0);
        check_eq("t3_ncs_release", SD_n_CS, 1);
        set_cs(1'b1);
        check_eq("t3_ncs_reselect", SD_n_CS, 0);

        // back-to-back: second start lands in the done cycle
        do_start(8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (16 * SDIV) tick();
        check_eq("t4_done_now", done, 1);
        do_start(8'hFF, 8'hE7, 1'b0, 1'b0, 1'b0);
        wait_done();

        // random bytes
        for (int k = 0; k < 4; k++) begin
            tx = 8'($urandom_range(0, 255));
            rp = 8'($urandom_range(0, 255));
            do_start(tx, rp, 1'b0, 1'b0, 1'b0);
            wait_done();
            tick();
        end

        // fast select; toggling fast_sel mid-byte must not matter
        do_start(8'h96, 8'h69, 1'b1, 1'b0, 1'b0);
        fast_sel = 1'b0;
        wait_done();
        do_start(8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);
        fast_sel = 1'b1;
        wait_done();
        fast_sel = 1'b0;
        tick();

        // reset mid-byte
        do_start(8'h55, 8'hAA, 1'b0, 1'b0, 1'b0);
        repeat (20) tick();
        reset = 1'b1;
        #2;
        check_eq("t1_ncs", SD_n_CS, 1);
        check_eq("t1_ck", SD_CK, 0);
        check_eq("t1_di", SD_DI, 1);
        check_eq("t1_busy", busy, 0);
        check_eq("t1_rd_data", rd_data, 8'hFF);
        check_eq("t1_done", done, 0);
        repeat (2) tick();
        reset   = 1'b0;
        exp_ncs = 1'b1;
        for (int i = 0; i < 16 * SDIV + 8; i++) begin
            check_eq("t1_no_done", done, 0);
            tick();
        end
        do_start(8'h81, 8'h7E, 1'b0, 1'b1, 1'b1);
        wait_done();

        repeat (4) tick();
        check_eq("exp_q_drained", exp_q.size(), 0);
        check_eq("bit_q_drained", exp_bit_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
